// File: rtl/ps_pkg.sv
// Shared definitions for the parking-sensor chain: clock rate, sensor scale
// and the ranger FSM state encoding.
package ps_pkg;

    localparam int unsigned CLK_FREQ      = 50_000_000;
    localparam int unsigned CYCLES_PER_CM = 2915;
    localparam int unsigned CNT_W         = 22;
    localparam int unsigned CM_W          = 9;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DIVIDE,
        DONE
    } ranger_state_t;

    // Converts a distance in cm into echo-width cycles, the unit of dist_cycles.
    function automatic logic [CNT_W-1:0] cm_to_cycles(input int unsigned cm);
        return CNT_W'(cm * CYCLES_PER_CM);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared by a
// synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let both flops sample on the same edge;
    // blocking ones would collapse the chain into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Periodic ultrasonic distance measurement: fires a trigger pulse, times the
// echo width and converts it to cm by repeated subtraction.
module ultrasonic_ranger #(
    parameter int unsigned CYCLES_PER_CM = ps_pkg::CYCLES_PER_CM,
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned PERIOD_CYCLES = 4_000_000,
    parameter int unsigned START_TIMEOUT = 50_000,
    parameter int unsigned MAX_CM        = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo,
    output logic        trig,
    output logic [21:0] dist_cycles,
    output logic [8:0]  dist_cm,
    output logic        dist_valid,
    output logic        out_of_range,
    output logic        busy
);

    import ps_pkg::*;

    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WIDTH_LIMIT  = CNT_W'(MAX_CM * CYCLES_PER_CM);
    localparam logic [CNT_W-1:0] DIVISOR      = CNT_W'(CYCLES_PER_CM);

    ranger_state_t    state;
    ranger_state_t    next_state;
    logic             echo_s;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] rem;
    logic [CM_W-1:0]  q;
    logic             timed_out;

    sync_2ff u_echo_sync (
        .clk (clk),
        .rst (rst),
        .d   (echo),
        .q   (echo_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case, so no path through
    // this block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (period_cnt == '0 && !echo_s) next_state = TRIG;
            end
            TRIG: begin
                if (timer == TRIG_LAST) next_state = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_s)                     next_state = MEASURE;
                else if (timer == TIMEOUT_LAST) next_state = DONE;
            end
            MEASURE: begin
                if (width == WIDTH_LIMIT) next_state = DONE;
                else if (!echo_s)         next_state = DIVIDE;
            end
            DIVIDE: begin
                if (rem < DIVISOR) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Period timer runs regardless of state; a busy FSM simply misses the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // One timer serves both the trigger length and the echo-start timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= '0;
        end else if (state == TRIG || state == WAIT_ECHO) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width     <= '0;
            rem       <= '0;
            q         <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == WAIT_ECHO && echo_s) begin
                width <= CNT_W'(1);
            end else if (state == MEASURE && echo_s && width != WIDTH_LIMIT) begin
                width <= width + 1'b1;
            end

            if (state == MEASURE && next_state == DIVIDE) begin
                rem <= width;
                q   <= '0;
            end else if (state == DIVIDE && rem >= DIVISOR) begin
                rem <= rem - DIVISOR;
                q   <= q + 1'b1;
            end

            // Only the DIVIDE exit into DONE carries a real distance.
            if (next_state == DONE) begin
                timed_out <= (state != DIVIDE);
            end
        end
    end

    // Result registers follow the state register, so they update one edge
    // after DONE is entered and hold until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig         <= 1'b0;
            dist_valid   <= 1'b0;
            dist_cycles  <= '0;
            dist_cm      <= '0;
            out_of_range <= 1'b0;
        end else begin
            trig       <= (state == TRIG);
            dist_valid <= (state == DONE);
            if (state == DONE) begin
                dist_cycles  <= timed_out ? '0 : width;
                dist_cm      <= timed_out ? '0 : q;
                out_of_range <= timed_out;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with a scoreboard of expected strobes.
module tb_ultrasonic_ranger;

    localparam int CPC    = 100;
    localparam int TRIG_N = 10;
    localparam int PERIOD = 20000;
    localparam int TMO    = 1000;
    localparam int MAXCM  = 100;
    localparam int LIMIT  = MAXCM * CPC;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        echo = 1'b0;
    logic        trig;
    logic [21:0] dist_cycles;
    logic [8:0]  dist_cm;
    logic        dist_valid;
    logic        out_of_range;
    logic        busy;

    ultrasonic_ranger #(
        .CYCLES_PER_CM (CPC),
        .TRIG_CYCLES   (TRIG_N),
        .PERIOD_CYCLES (PERIOD),
        .START_TIMEOUT (TMO),
        .MAX_CM        (MAXCM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .echo         (echo),
        .trig         (trig),
        .dist_cycles  (dist_cycles),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .out_of_range (out_of_range),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cm;
        int    cycles;
        bit    oor;
        int    due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rel    = 0;
    bit   rst_seen = 1'b1;
    logic [8:0]  held_cm     = '0;
    logic [21:0] held_cycles = '0;
    logic        held_oor    = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int cm, input int cycles,
                            input bit oor, input int due);
        exp_t e;
        e.tag = tag; e.cm = cm; e.cycles = cycles; e.oor = oor; e.due = due;
        sb.push_back(e);
    endtask

    // Output monitor: every strobe must match the oldest expectation, and the
    // result registers must hold steady between strobes.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            held_cm     = '0;
            held_cycles = '0;
            held_oor    = 1'b0;
        end else if (dist_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_cm"},     32'(dist_cm),      32'(e.cm));
                check({e.tag, "_cycles"}, 32'(dist_cycles),  32'(e.cycles));
                check({e.tag, "_oor"},    32'(out_of_range), 32'(e.oor));
                check({e.tag, "_when"},   32'(cyc),          32'(e.due));
                held_cm     = 9'(e.cm);
                held_cycles = 22'(e.cycles);
                held_oor    = e.oor;
            end
        end else begin
            check("hold_result", {out_of_range, dist_cm, dist_cycles},
                  {held_oor, held_cm, held_cycles});
        end
    end

    task automatic apply_reset();
        rst  = 1'b1;
        echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
    endtask

    // Waits (bounded) for trig, returns the cycle it was first seen high and
    // how many cycles it stayed high; returns at the first low negedge.
    task automatic wait_trig(input int budget, output int rise, output int len);
        rise = -1;
        len  = 0;
        for (int i = 0; i < budget && trig !== 1'b1; i++) @(negedge clk);
        if (trig !== 1'b1) begin
            check("trig_never_rose", 32'd0, 32'd1);
        end else begin
            rise = cyc;
            while (trig === 1'b1 && len < 1000) begin
                len++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check({tag, "_strobe_seen"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic measure(input string tag, input int n);
        int rise, len, q;
        apply_reset();
        wait_trig(50, rise, len);
        check({tag, "_trig_rise"}, 32'(rise), 32'(rel + 2));
        check({tag, "_trig_len"},  32'(len),  32'(TRIG_N));
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (n) @(negedge clk);
        echo = 1'b0;
        q = n / CPC;
        push_exp(tag, q, n, 1'b0, cyc + 1 + q + 4);
        wait_drain(tag, q + 30);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, len, n_trig, t_rise;

        // Reset holds every output low, even with echo high.
        rst  = 1'b1;
        echo = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_trig",   32'(trig),         32'd0);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_valid",  32'(dist_valid),   32'd0);
        check("rst_cm",     32'(dist_cm),      32'd0);
        check("rst_cycles", 32'(dist_cycles),  32'd0);
        check("rst_oor",    32'(out_of_range), 32'd0);
        echo = 1'b0;

        // Normal measurement and quotient boundaries.
        measure("p1250", 1250);
        measure("p99",   99);
        measure("p100",  100);
        measure("p199",  199);

        // No echo: timeout 1000 cycles after trig falls.
        apply_reset();
        wait_trig(50, rise, len);
        check("noecho_trig_len", 32'(len), 32'(TRIG_N));
        push_exp("noecho", 0, 0, 1'b1, cyc + TMO);
        wait_drain("noecho", TMO + 30);
        check("noecho_busy_after", 32'(busy), 32'd0);

        // Echo stuck high: width-limit timeout, no new trig while echo high.
        apply_reset();
        wait_trig(50, rise, len);
        echo = 1'b1;
        push_exp("stuck", 0, 0, 1'b1, cyc + 1 + LIMIT + 3);
        n_trig = 0;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if (trig === 1'b1) n_trig++;
            if (i == 12000) check("stuck_busy_idle", 32'(busy), 32'd0);
        end
        echo = 1'b0;
        check("stuck_no_trig", 32'(n_trig), 32'd0);
        wait_drain("stuck", 10);

        // Reset mid-MEASURE discards the measurement and restarts the period.
        apply_reset();
        wait_trig(50, rise, len);
        echo = 1'b1;
        repeat (300) @(negedge clk);
        check("mr_busy_before", 32'(busy), 32'd1);
        rst  = 1'b1;
        echo = 1'b0;
        @(negedge clk);
        check("mr_trig",  32'(trig),       32'd0);
        check("mr_busy",  32'(busy),       32'd0);
        check("mr_valid", 32'(dist_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_trig_edge1", 32'(trig), 32'd0);
        @(negedge clk);
        check("mr_trig_edge2", 32'(trig), 32'd1);

        // Reset mid-trig drops trig at the next edge.
        rst = 1'b1;
        @(negedge clk);
        check("mt_trig", 32'(trig), 32'd0);
        check("mt_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (500) @(negedge clk);

        // Long echo spanning the period wrap: timeout, then the wrap is skipped.
        apply_reset();
        wait_trig(50, rise, len);
        repeat (800) @(negedge clk);
        echo = 1'b1;
        push_exp("wrap", 0, 0, 1'b1, cyc + 1 + LIMIT + 3);
        n_trig = 0;
        for (int i = 0; i < 19500; i++) begin
            @(negedge clk);
            if (trig === 1'b1) n_trig++;
        end
        echo = 1'b0;
        check("wrap_no_trig_during_echo", 32'(n_trig), 32'd0);
        check("wrap_strobe_seen", 32'(sb.size()), 32'd0);
        sb.delete();
        wait_trig(25000, t_rise, len);
        check("wrap_next_trig", 32'(t_rise), 32'(rel + 2 + 2 * PERIOD));
        check("wrap_next_trig_len", 32'(len), 32'(TRIG_N));

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
